bn_stats_accumulator: RTL and testbench



---
 rtl/bn_stats_accumulator_pkg.sv | 19 +
 rtl/bn_var_finalize.sv | 32 +++
 rtl/bn_stats_accumulator.sv | 124 ++++++++++++
 tb/tb_bn_stats_accumulator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bn_stats_accumulator_pkg.sv
// Shared state encodings and derived accumulator widths for the batch-stats block.
package bn_stats_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    CALC_MEAN = 2'd1,
    CALC_VAR  = 2'd2,
    OUTPUT    = 2'd3
  } bns_state_t;

  function automatic int sum_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  function automatic int sq_w(input int data_w, input int log2_n);
    return 2 * data_w + log2_n;
  endfunction

endpackage

// File: rtl/bn_var_finalize.sv
// Combinational variance finalize: E[x^2] - mean^2, clamped at 0 and saturated
// to the largest positive DATA_WIDTH value.
module bn_var_finalize #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2*DATA_WIDTH-1:0] i_ex2,
  input  logic [DATA_WIDTH-1:0]   i_mean,
  output logic [DATA_WIDTH-1:0]   o_var
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW:0] VMAX = (PW+1)'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);

  logic signed [PW-1:0] w_mean_sx;
  logic signed [PW-1:0] w_msq_s;
  logic [PW:0]          w_diff;

  assign w_mean_sx = {{DATA_WIDTH{i_mean[DATA_WIDTH-1]}}, i_mean};
  assign w_msq_s   = w_mean_sx * w_mean_sx;
  // One extra bit so a negative difference shows up as the top bit.
  assign w_diff    = {1'b0, i_ex2} - {1'b0, $unsigned(w_msq_s)};

  always_comb begin
    o_var = w_diff[DATA_WIDTH-1:0];
    if (w_diff[PW]) begin
      o_var = '0;
    end else if (w_diff > VMAX) begin
      o_var = VMAX[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/bn_stats_accumulator.sv
// Accumulates sum and sum of squares over 2^LOG2_N samples, then emits mean and
// variance two cycles after the last accept, held under valid/ready until consumed.
module bn_stats_accumulator
  import bn_stats_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] stats_mean,
  output logic [DATA_WIDTH-1:0] stats_var,
  output logic                  stats_valid,
  input  logic                  stats_ready,
  output logic                  busy
);

  localparam int SUM_W = sum_w(DATA_WIDTH, LOG2_N);
  localparam int SQ_W  = sq_w(DATA_WIDTH, LOG2_N);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam logic [LOG2_N-1:0] LAST_CNT = LOG2_N'((1 << LOG2_N) - 1);

  bns_state_t r_state, w_state_nxt;
  logic [LOG2_N-1:0]        r_count;
  logic signed [SUM_W-1:0]  r_sum;
  logic [SQ_W-1:0]          r_sumsq;
  logic [DATA_WIDTH-1:0]    r_mean;
  logic [DATA_WIDTH-1:0]    r_var;
  logic                     r_valid;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_consume;
  logic signed [PW-1:0]     w_din_sx;
  logic signed [PW-1:0]     w_sq;
  logic signed [SUM_W-1:0]  w_sum_sx;
  logic [PW-1:0]            w_ex2;
  logic [DATA_WIDTH-1:0]    w_var;

  assign ready_in    = (r_state == ACCUM);
  assign w_accept    = valid_in && ready_in && !clear;
  assign w_last      = w_accept && (r_count == LAST_CNT);
  assign w_consume   = r_valid && stats_ready;
  assign w_din_sx    = {{DATA_WIDTH{data_in[DATA_WIDTH-1]}}, data_in};
  assign w_sq        = w_din_sx * w_din_sx;
  assign w_sum_sx    = {{LOG2_N{data_in[DATA_WIDTH-1]}}, data_in};
  // Dropping the low LOG2_N bits is the floor divide by N for both accumulators.
  assign w_ex2       = r_sumsq[SQ_W-1:LOG2_N];

  assign stats_mean  = r_mean;
  assign stats_var   = r_var;
  assign stats_valid = r_valid;
  assign busy        = (r_state != ACCUM) || (r_count != '0);

  bn_var_finalize #(.DATA_WIDTH(DATA_WIDTH)) u_var_finalize (
    .i_ex2  (w_ex2),
    .i_mean (r_mean),
    .o_var  (w_var)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACCUM;
    end else begin
      unique case (r_state)
        ACCUM:     if (w_last) w_state_nxt = CALC_MEAN;
        CALC_MEAN: w_state_nxt = CALC_VAR;
        CALC_VAR:  w_state_nxt = OUTPUT;
        OUTPUT:    if (w_consume) w_state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sum   <= '0;
      r_sumsq <= '0;
      r_mean  <= '0;
      r_var   <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      // Results survive a flush; only the batch in flight is discarded.
      r_count <= '0;
      r_sum   <= '0;
      r_sumsq <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_sum   <= r_sum + w_sum_sx;
            r_sumsq <= r_sumsq + SQ_W'($unsigned(w_sq));
            r_count <= w_last ? '0 : r_count + 1'b1;
          end
        end
        CALC_MEAN: r_mean <= r_sum[SUM_W-1:LOG2_N];
        CALC_VAR: begin
          r_var   <= w_var;
          r_valid <= 1'b1;
        end
        OUTPUT: begin
          if (w_consume) begin
            r_valid <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_sumsq <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bn_stats_accumulator.sv
// Directed-vector bench for bn_stats_accumulator: hand-computed mean/variance,
// handshake timing, backpressure, clear and asynchronous reset.
module tb_bn_stats_accumulator;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic        clear;
  logic [15:0] stats_mean;
  logic [15:0] stats_var;
  logic        stats_valid;
  logic        stats_ready;
  logic        busy;

  int n_vec;
  int n_miss;
  logic signed [15:0] samp [16];

  bn_stats_accumulator #(.DATA_WIDTH(16), .LOG2_N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .clear       (clear),
    .stats_mean  (stats_mean),
    .stats_var   (stats_var),
    .stats_valid (stats_valid),
    .stats_ready (stats_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      data_in  = samp[i];
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  // Called right after the 16th accept edge; ends with results visible.
  task automatic expect_result(input string tag, input logic [15:0] em, input logic [15:0] ev);
    chk({tag, "_rdy_after_last"}, {15'd0, ready_in}, 16'd0);
    chk({tag, "_busy_after_last"}, {15'd0, busy}, 16'd1);
    chk({tag, "_vld_t1"}, {15'd0, stats_valid}, 16'd0);
    tick();
    chk({tag, "_vld_t2m"}, {15'd0, stats_valid}, 16'd0);
    tick();
    chk({tag, "_vld"}, {15'd0, stats_valid}, 16'd1);
    chk({tag, "_mean"}, stats_mean, em);
    chk({tag, "_var"}, stats_var, ev);
  endtask

  task automatic expect_consumed(input string tag);
    tick();
    chk({tag, "_vld_drop"}, {15'd0, stats_valid}, 16'd0);
    chk({tag, "_rdy_back"}, {15'd0, ready_in}, 16'd1);
    chk({tag, "_busy_idle"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic fill_const(input logic signed [15:0] v);
    for (int i = 0; i < 16; i++) samp[i] = v;
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    data_in     = '0;
    valid_in    = 1'b0;
    clear       = 1'b0;
    stats_ready = 1'b1;
    #3;
    chk("rst_mean", stats_mean, 16'd0);
    chk("rst_var", stats_var, 16'd0);
    chk("rst_vld", {15'd0, stats_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_rdy", {15'd0, ready_in}, 16'd1);
    #10 rst_n = 1'b1;
    tick();

    // Constant 5: mean 5, variance 0, valid for exactly one cycle.
    fill_const(16'sd5);
    feed(16);
    expect_result("const5", 16'd5, 16'd0);
    expect_consumed("const5");

    // Ramp 0..15: sum 120 -> 7; sumsq 1240 -> 77; 77 - 49 = 28.
    for (int i = 0; i < 16; i++) samp[i] = 16'(i);
    feed(16);
    expect_result("ramp", 16'd7, 16'd28);
    expect_consumed("ramp");

    // Alternating +/-10: mean 0, variance 100.
    for (int i = 0; i < 16; i++) samp[i] = (i % 2 == 0) ? 16'sd10 : -16'sd10;
    feed(16);
    expect_result("alt10", 16'd0, 16'd100);
    expect_consumed("alt10");

    // 15 x -3 and one -4: sum -49 -> floor -4; ex2 151>>4 = 9; 9 - 16 clamps to 0.
    fill_const(-16'sd3);
    samp[15] = -16'sd4;
    feed(16);
    expect_result("negclamp", 16'hFFFC, 16'd0);
    expect_consumed("negclamp");

    // Extremes: sum -8 -> mean -1; ex2 1073709056 - 1 saturates.
    for (int i = 0; i < 16; i++) samp[i] = (i % 2 == 0) ? 16'sh7FFF : 16'sh8000;
    feed(16);
    expect_result("sat", 16'hFFFF, 16'h7FFF);
    expect_consumed("sat");

    // Backpressure: results held, samples offered during OUTPUT are ignored.
    stats_ready = 1'b0;
    for (int i = 0; i < 16; i++) samp[i] = 16'(i);
    feed(16);
    expect_result("bp", 16'd7, 16'd28);
    for (int c = 0; c < 5; c++) begin
      data_in  = 16'($urandom_range(1, 16'h7FFF));
      valid_in = 1'b1;
      tick();
      chk("bp_hold_vld", {15'd0, stats_valid}, 16'd1);
      chk("bp_hold_mean", stats_mean, 16'd7);
      chk("bp_hold_var", stats_var, 16'd28);
      chk("bp_hold_rdy", {15'd0, ready_in}, 16'd0);
    end
    valid_in    = 1'b0;
    stats_ready = 1'b1;
    expect_consumed("bp");
    // A batch right after release must be a full 16 fresh samples.
    fill_const(16'sd5);
    feed(16);
    expect_result("post_bp", 16'd5, 16'd0);
    expect_consumed("post_bp");

    // Clear after 7 x 100, with a sample offered in the clear cycle.
    fill_const(16'sd100);
    feed(7);
    chk("pre_clr_busy", {15'd0, busy}, 16'd1);
    data_in  = 16'sd100;
    valid_in = 1'b1;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    valid_in = 1'b0;
    chk("clr_busy", {15'd0, busy}, 16'd0);
    chk("clr_rdy", {15'd0, ready_in}, 16'd1);
    chk("clr_mean_kept", stats_mean, 16'd5);
    fill_const(16'sd2);
    feed(16);
    expect_result("post_clr", 16'd2, 16'd0);
    expect_consumed("post_clr");

    // Asynchronous reset mid-batch, asserted away from any clock edge.
    fill_const(16'sd9);
    feed(5);
    chk("mid_busy", {15'd0, busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mean", stats_mean, 16'd0);
    chk("arst_var", stats_var, 16'd0);
    chk("arst_vld", {15'd0, stats_valid}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_rdy", {15'd0, ready_in}, 16'd1);
    #10 rst_n = 1'b1;
    tick();
    fill_const(-16'sd7);
    feed(16);
    expect_result("post_rst", 16'hFFF9, 16'd0);
    expect_consumed("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
